// File: rtl/minisrc_ctrl_pkg.sv
// Shared opcodes, ALU codes, FSM states and instruction classes for the Mini SRC control unit.
package minisrc_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALTED
    } state_t;

    typedef enum logic [3:0] {
        RTYPE, IMM, LD, LDI, ST, BR, JR, NOP, HALT, MULDIV, ILLEGAL
    } instr_class_t;

    typedef struct packed {
        logic       PC_in;
        logic       IR_in;
        logic       Y_in;
        logic       Z_in;
        logic       HI_in;
        logic       LO_in;
        logic       MAR_in;
        logic       MDR_in;
        logic       IncPC;
        logic       CON_in;
        logic       PC_out;
        logic       Zhigh_out;
        logic       Zlow_out;
        logic       HI_out;
        logic       LO_out;
        logic       MDR_out;
        logic       C_out;
        logic       BAout;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       Rin;
        logic       Rout;
        logic       Read;
        logic       Write;
        logic [4:0] alu;
    } ctrl_t;

    // Immediate ops reuse the ALU code of their register-register counterpart.
    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ANDI: imm_alu = ALU_AND;
            OP_ORI:  imm_alu = ALU_OR;
            default: imm_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/minisrc_control_unit_if.sv
// Control bundle between the Mini SRC control unit (master) and the datapath (slave).
interface minisrc_ctrl_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC, CON_in;
    logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out, BAout;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic        Read, Write;
    logic [4:0]  alu_instruction_bits;
    logic        run;
    logic        illegal;

    modport master (
        input  ir, con_ff, stop,
        output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC, CON_in,
        output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out, BAout,
        output Gra, Grb, Grc, Rin, Rout, Read, Write, alu_instruction_bits, run, illegal
    );

    modport slave (
        output ir, con_ff, stop,
        input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC, CON_in,
        input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out, BAout,
        input  Gra, Grb, Grc, Rin, Rout, Read, Write, alu_instruction_bits, run, illegal
    );
endinterface

// File: rtl/minisrc_op_decode.sv
// Opcode to instruction-class decoder; mul/div are legal only when MINISRC_MULDIV_EN is defined.
module minisrc_op_decode
    import minisrc_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      cls = RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:             cls = IMM;
            OP_LD:                                cls = LD;
            OP_LDI:                               cls = LDI;
            OP_ST:                                cls = ST;
            OP_BR:                                cls = BR;
            OP_JR:                                cls = JR;
            OP_NOP:                               cls = NOP;
            OP_HALT:                              cls = HALT;
`ifdef MINISRC_MULDIV_EN
            OP_MUL, OP_DIV:                       cls = MULDIV;
`else
            OP_MUL, OP_DIV:                       cls = ILLEGAL;
`endif
            default:                              cls = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/minisrc_control_unit.sv
// Hardwired Moore control unit sequencing fetch/decode/execute for the Mini SRC datapath.
// Build with MINISRC_MULDIV_EN to accept mul/div.
module minisrc_control_unit
    import minisrc_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    minisrc_ctrl_if.master bus
);

    state_t       state, state_nx;
    instr_class_t cls;
    ctrl_t        c;
    logic         illegal_q;
    logic [4:0]   opcode;

    assign opcode = bus.ir[31:27];

    minisrc_op_decode u_dec (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= RESET;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                                 illegal_q <= 1'b0;
        else if (state == T3 && cls == ILLEGAL)   illegal_q <= 1'b1;
    end

    // stop only matters on the edge that closes an instruction
    always_comb begin
        state_t done;
        done     = bus.stop ? PAUSE : T0;
        state_nx = state;
        case (state)
            RESET:  state_nx = T0;
            T0:     state_nx = T1;
            T1:     state_nx = T2;
            T2:     state_nx = T3;
            T3: case (cls)
                    JR, NOP:       state_nx = done;
                    HALT, ILLEGAL: state_nx = HALTED;
                    default:       state_nx = T4;
                endcase
            T4:     state_nx = T5;
            T5: case (cls)
                    RTYPE, IMM, LDI: state_nx = done;
                    default:         state_nx = T6;
                endcase
            T6: case (cls)
                    LD, ST:  state_nx = T7;
                    default: state_nx = done;
                endcase
            T7:     state_nx = done;
            PAUSE:  state_nx = bus.stop ? PAUSE : T0;
            HALTED: state_nx = HALTED;
            default: state_nx = RESET;
        endcase
    end

    always_comb begin
        c = '0;
        case (state)
            T0: begin c.PC_out = 1'b1; c.MAR_in = 1'b1; c.IncPC = 1'b1; c.Z_in = 1'b1; end
            T1: begin c.Zlow_out = 1'b1; c.PC_in = 1'b1; c.Read = 1'b1; c.MDR_in = 1'b1; end
            T2: begin c.MDR_out = 1'b1; c.IR_in = 1'b1; end
            T3: case (cls)
                    RTYPE, IMM:   begin c.Grb = 1'b1; c.Rout = 1'b1; c.Y_in = 1'b1; end
                    MULDIV:       begin c.Gra = 1'b1; c.Rout = 1'b1; c.Y_in = 1'b1; end
                    LD, LDI, ST:  begin c.Grb = 1'b1; c.BAout = 1'b1; c.Y_in = 1'b1; end
                    BR:           begin c.Gra = 1'b1; c.Rout = 1'b1; c.CON_in = 1'b1; end
                    JR:           begin c.Gra = 1'b1; c.Rout = 1'b1; c.PC_in = 1'b1; end
                    default:      ;
                endcase
            T4: case (cls)
                    RTYPE:  begin c.Grc = 1'b1; c.Rout = 1'b1; c.Z_in = 1'b1; c.alu = opcode; end
                    IMM:    begin c.C_out = 1'b1; c.Z_in = 1'b1; c.alu = imm_alu(opcode); end
                    LD, LDI, ST:
                            begin c.C_out = 1'b1; c.Z_in = 1'b1; c.alu = ALU_ADD; end
                    BR:     begin c.PC_out = 1'b1; c.Y_in = 1'b1; end
                    MULDIV: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Z_in = 1'b1; c.alu = opcode; end
                    default: ;
                endcase
            T5: case (cls)
                    RTYPE, IMM, LDI: begin c.Zlow_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
                    LD, ST:          begin c.Zlow_out = 1'b1; c.MAR_in = 1'b1; end
                    BR:              begin c.C_out = 1'b1; c.Z_in = 1'b1; c.alu = ALU_ADD; end
                    MULDIV:          begin c.Zlow_out = 1'b1; c.LO_in = 1'b1; end
                    default:         ;
                endcase
            T6: case (cls)
                    LD:     begin c.Read = 1'b1; c.MDR_in = 1'b1; end
                    ST:     begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDR_in = 1'b1; end
                    // branch target is committed only when CON was set in T3
                    BR:     begin c.Zlow_out = bus.con_ff; c.PC_in = bus.con_ff; end
                    MULDIV: begin c.Zhigh_out = 1'b1; c.HI_in = 1'b1; end
                    default: ;
                endcase
            T7: case (cls)
                    LD:      begin c.MDR_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
                    ST:      c.Write = 1'b1;
                    default: ;
                endcase
            default: ;
        endcase
    end

    assign bus.PC_in     = c.PC_in;
    assign bus.IR_in     = c.IR_in;
    assign bus.Y_in      = c.Y_in;
    assign bus.Z_in      = c.Z_in;
    assign bus.HI_in     = c.HI_in;
    assign bus.LO_in     = c.LO_in;
    assign bus.MAR_in    = c.MAR_in;
    assign bus.MDR_in    = c.MDR_in;
    assign bus.IncPC     = c.IncPC;
    assign bus.CON_in    = c.CON_in;
    assign bus.PC_out    = c.PC_out;
    assign bus.Zhigh_out = c.Zhigh_out;
    assign bus.Zlow_out  = c.Zlow_out;
    assign bus.HI_out    = c.HI_out;
    assign bus.LO_out    = c.LO_out;
    assign bus.MDR_out   = c.MDR_out;
    assign bus.C_out     = c.C_out;
    assign bus.BAout     = c.BAout;
    assign bus.Gra       = c.Gra;
    assign bus.Grb       = c.Grb;
    assign bus.Grc       = c.Grc;
    assign bus.Rin       = c.Rin;
    assign bus.Rout      = c.Rout;
    assign bus.Read      = c.Read;
    assign bus.Write     = c.Write;
    assign bus.alu_instruction_bits = c.alu;
    assign bus.run       = (state inside {T0, T1, T2, T3, T4, T5, T6, T7});
    assign bus.illegal   = illegal_q;

endmodule

// File: doc/minisrc_control_unit.md
Name: minisrc_control_unit

Overview:
Hardwired Moore control unit for the Mini SRC datapath. It replaces bench-driven control with a state machine that sequences fetch (T0–T2), decode and execute for a subset of the ISA. Its outputs drive the datapath's existing control inputs one-to-one. It observes only the IR contents and the CON flip-flop.

Parameters:
ALU_ADD, 5'b00011, ALU op code used for address, branch and addi arithmetic
ALU_AND, 5'b00101, ALU op code for andi
ALU_OR, 5'b00110, ALU op code for ori

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
ir  in  32  IR_Data from datapath; opcode is ir[31:27]
con_ff  in  1  CON_out from the CON FF logic
stop  in  1  pause request, sampled at instruction boundary
PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, IncPC, CON_in  out  1 each  register load enables
PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, C_out, BAout  out  1 each  bus drive enables
Gra, Grb, Grc, Rin, Rout  out  1 each  select-and-encode controls
Read, Write  out  1 each  memory strobes
alu_instruction_bits  out  5  ALU operation; 0 when unused
run  out  1  1 while executing instructions
illegal  out  1  sticky: an unsupported opcode was decoded

Behaviour:
- clr low (async): state=RESET; every output 0; illegal cleared. First rising edge after release: RESET→T0.
- Moore outputs decode from the registered state plus ir; the only exception is the br T6 qualification. Each listed signal is high for exactly one clock.
- run=1 in T0..T7; run=0 in RESET, PAUSE and HALTED.
- Fetch:
  - T0: PC_out, MAR_in, IncPC, Z_in.
  - T1: Zlow_out, PC_in, Read, MDR_in.
  - T2: MDR_out, IR_in.
  - T3: decode ir[31:27], which is valid because IR loaded at the end of T2.
- R-type (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: Grb, Rout, Y_in.
  - T4: Grc, Rout, Z_in, alu_instruction_bits=opcode.
  - T5: Zlow_out, Gra, Rin.
- Immediate (addi 01100, andi 01101, ori 01110): T3 as R-type; T4 C_out, Z_in, alu=ALU_ADD/ALU_AND/ALU_OR; T5 as R-type.
- ldi 00001:
  - T3: Grb, BAout, Y_in.
  - T4: C_out, Z_in, alu=ALU_ADD.
  - T5: Zlow_out, Gra, Rin.
- ld 00000:
  - T3, T4 as ldi.
  - T5: Zlow_out, MAR_in.
  - T6: Read, MDR_in.
  - T7: MDR_out, Gra, Rin.
- st 00010:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDR_in (Read=0).
  - T7: Write.
- br 10011:
  - T3: Gra, Rout, CON_in.
  - T4: PC_out, Y_in.
  - T5: C_out, Z_in, alu=ALU_ADD.
  - T6: if con_ff=1, Zlow_out and PC_in; otherwise no outputs. con_ff is sampled in T6.
- jr 10100: T3: Gra, Rout, PC_in.
- nop 11010: T3 asserts no outputs.
- halt 11011: T3 asserts no outputs, then →HALTED. HALTED is left only via clr.
- Any other opcode: T3 asserts no outputs; illegal←1; →HALTED.
- Instruction end: the last T-state of each class returns to T0, or to PAUSE if stop=1 at that edge. PAUSE→T0 on the first edge with stop=0. stop is ignored mid-instruction and in HALTED.
- Reset mid-instruction aborts immediately; outputs are 0 asynchronously.

Optional Feature:
MINISRC_MULDIV_EN
- Defined: mul 10000 and div 01111 are legal.
  - T3: Gra, Rout, Y_in.
  - T4: Grb, Rout, Z_in, alu=opcode.
  - T5: Zlow_out, LO_in.
  - T6: Zhigh_out, HI_in.
  - Then →T0.
- Undefined: mul and div are treated as illegal opcodes.

Decomposition:
- Package minisrc_ctrl_pkg holds:
  - 5-bit opcode constants.
  - ALU code constants.
  - State enum: RESET, T0–T7, PAUSE, HALTED.
  - Instruction-class enum: RTYPE, IMM, LD, LDI, ST, BR, JR, NOP, HALT, MULDIV, ILLEGAL.
- Sub-module minisrc_op_decode: purely combinational opcode→class mapping, with the MINISRC_MULDIV_EN gating inside it.

Test Plan:
- Reset then release: all outputs 0 while clr=0. First cycle after release is T0 with PC_out=MAR_in=IncPC=Z_in=1, run=1.
- ir=0x1A920000 (add R5,R2,R4): T3 Grb+Rout+Y_in; T4 Grc+Rout+Z_in, alu=00011; T5 Zlow_out+Gra+Rin; next cycle is T0.
- ir=0x9B000019 (brzr R6,25) with con_ff=1 in T6: T3 CON_in=1; T6 Zlow_out=PC_in=1. Repeat with con_ff=0: T6 PC_in=0; then T0.
- ir=0x00000000 (ld): Read=1 in T1 and T6; T7 MDR_out+Rin; instruction totals 8 cycles. st variant: Write=1 only in T7.
- ir=0xD8000000 (halt): run=0 from the cycle after T3 and stays 0 for 10+ cycles. ir=0xB8000000 (out, unsupported): illegal=1.
- stop=1 asserted during T4 of add: T5 completes, then PAUSE with run=0. stop=0 → T0 on the next cycle. Build with MINISRC_MULDIV_EN and mul: T5 LO_in=1, T6 HI_in=1.
